// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and default widths for the conv layer sequencer
package conv_seq_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CFG_W  = 32;
  localparam int DEF_CNT_W  = 24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry skid buffer with registered stream outputs
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         empty
);

  logic [W-1:0] skid_data;
  logic         skid_valid;

  // Ready only needs the second slot: a full buffer is output reg + skid reg.
  assign s_tready = !skid_valid;
  assign empty    = !m_tvalid && !skid_valid;

  // Output register refills from the skid slot first, then from the input; a stalled output parks the input in the skid slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else begin
      if (!m_tvalid || m_tready) begin
        if (skid_valid) begin
          m_tdata    <= skid_data;
          m_tvalid   <= 1'b1;
          skid_valid <= 1'b0;
        end else if (s_tvalid) begin
          m_tdata  <= s_tdata;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else if (s_tvalid && !skid_valid) begin
        skid_data  <= s_tdata;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - one-launch-per-layer sequencer over output-channel groups (option: SEQ_GROUP_TLAST_EN)
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CFG_W  = DEF_CFG_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_idle,
  output logic                ap_done,
  output logic                ap_ready,
  input  logic [CFG_W-1:0]    cfg_num_groups,
  input  logic [CFG_W-1:0]    cfg_wt_base_addr,
  input  logic [CFG_W-1:0]    cfg_group_wt_stride,
  input  logic [CFG_W-1:0]    cfg_beats_per_group,
  output logic                core_start,
  output logic [CFG_W-1:0]    core_output_group,
  output logic [CFG_W-1:0]    core_wt_base_addr,
  input  logic                core_done,
  input  logic                s_core_tvalid,
  output logic                s_core_tready,
  input  logic [DATA_W-1:0]   s_core_tdata,
  input  logic [DATA_W/8-1:0] s_core_tkeep,
  output logic                m_axis_output_tvalid,
  input  logic                m_axis_output_tready,
  output logic [DATA_W-1:0]   m_axis_output_tdata,
  output logic [DATA_W/8-1:0] m_axis_output_tkeep,
  output logic                m_axis_output_tlast
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PAY_W  = DATA_W + KEEP_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t state, next_state;

  logic [CNT_W-1:0] num_groups_q;
  logic [CNT_W-1:0] beats_q;
  logic [CFG_W-1:0] stride_q;
  logic [CNT_W-1:0] group_idx;
  logic [CFG_W-1:0] wt_addr;
  logic [CNT_W-1:0] beat_cnt;
  logic             done_seen;

  logic             in_window;
  logic             skid_s_tready;
  logic             skid_empty;
  logic             beat_accept;
  logic [CNT_W-1:0] beat_cnt_p1;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic             last_group;
  logic             group_beat_last;
  logic             tlast_in;
  logic             group_complete;
  logic [PAY_W-1:0] skid_in;
  logic [PAY_W-1:0] skid_out;

  // Configuration bits above the counter width are deliberately ignored.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_num_groups[CFG_W-1:CNT_W], cfg_beats_per_group[CFG_W-1:CNT_W]};

  assign s_core_tready   = skid_s_tready && in_window && (beat_cnt < beats_q);
  assign beat_accept     = s_core_tvalid && s_core_tready;
  assign beat_cnt_p1     = beat_cnt + CNT_ONE;
  assign beat_cnt_nxt    = beat_accept ? beat_cnt_p1 : beat_cnt;
  assign last_group      = (group_idx == num_groups_q - CNT_ONE);
  assign group_beat_last = (beat_cnt_p1 == beats_q);
  // A core_done coinciding with the final beat still closes the group this cycle.
  assign group_complete  = (state == S_RUN) && (done_seen || core_done) && (beat_cnt_nxt == beats_q);

`ifdef SEQ_GROUP_TLAST_EN
  assign tlast_in = group_beat_last;
`else
  assign tlast_in = group_beat_last && last_group;
`endif

  assign skid_in = {s_core_tdata, s_core_tkeep, tlast_in};
  assign {m_axis_output_tdata, m_axis_output_tkeep, m_axis_output_tlast} = skid_out;

  assign core_output_group = CFG_W'(group_idx);
  assign core_wt_base_addr = wt_addr;

  axis_skid_buffer #(.W(PAY_W)) u_skid (
    .clk      (ap_clk),
    .resetn   (ap_rst_n),
    .s_tdata  (skid_in),
    .s_tvalid (beat_accept),
    .s_tready (skid_s_tready),
    .m_tdata  (skid_out),
    .m_tvalid (m_axis_output_tvalid),
    .m_tready (m_axis_output_tready),
    .empty    (skid_empty)
  );

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    next_state = state;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    ap_ready   = 1'b0;
    core_start = 1'b0;
    in_window  = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          next_state = (cfg_num_groups[CNT_W-1:0] == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        in_window  = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        in_window = 1'b1;
        if (group_complete) begin
          next_state = last_group ? S_DRAIN : S_LAUNCH;
        end
      end
      S_DRAIN: begin
        if (skid_empty) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        ap_done    = 1'b1;
        ap_ready   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Layer configuration latch, group/address stepping, beat counting and the sticky core_done flag.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      num_groups_q <= '0;
      beats_q      <= '0;
      stride_q     <= '0;
      group_idx    <= '0;
      wt_addr      <= '0;
      beat_cnt     <= '0;
      done_seen    <= 1'b0;
    end else begin
      if (state == S_IDLE && ap_start) begin
        num_groups_q <= cfg_num_groups[CNT_W-1:0];
        beats_q      <= cfg_beats_per_group[CNT_W-1:0];
        stride_q     <= cfg_group_wt_stride;
        group_idx    <= '0;
        wt_addr      <= cfg_wt_base_addr;
      end
      if (group_complete && !last_group) begin
        group_idx <= group_idx + CNT_ONE;
        wt_addr   <= wt_addr + stride_q;
      end
      // Counter and flag are cleared on entry to LAUNCH so beats taken during LAUNCH count.
      if (next_state == S_LAUNCH) begin
        beat_cnt  <= '0;
        done_seen <= 1'b0;
      end else begin
        beat_cnt <= beat_cnt_nxt;
        if (in_window && core_done) begin
          done_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - scoreboard bench for conv_layer_sequencer
module tb_conv_layer_sequencer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] g;
    logic [31:0] a;
  } start_t;

  logic        clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_idle, ap_done, ap_ready;
  logic [31:0] cfg_num_groups, cfg_wt_base_addr, cfg_group_wt_stride, cfg_beats_per_group;
  logic        core_start;
  logic [31:0] core_output_group, core_wt_base_addr;
  logic        core_done;
  logic        s_core_tvalid, s_core_tready;
  logic [63:0] s_core_tdata;
  logic [7:0]  s_core_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;

  beat_t  exp_q[$];
  start_t start_q[$];
  int     errors = 0;
  int     checks = 0;
  int     done_cnt = 0;
  int     cyc = 0;
  int     last_hs_cyc = 0;
  bit     chk_done_lat = 0;
  bit     toggle_mode = 0;
  bit     prev_stall = 0;
  beat_t  prev_beat;

  conv_layer_sequencer dut (
    .ap_clk               (clk),
    .ap_rst_n             (ap_rst_n),
    .ap_start             (ap_start),
    .ap_idle              (ap_idle),
    .ap_done              (ap_done),
    .ap_ready             (ap_ready),
    .cfg_num_groups       (cfg_num_groups),
    .cfg_wt_base_addr     (cfg_wt_base_addr),
    .cfg_group_wt_stride  (cfg_group_wt_stride),
    .cfg_beats_per_group  (cfg_beats_per_group),
    .core_start           (core_start),
    .core_output_group    (core_output_group),
    .core_wt_base_addr    (core_wt_base_addr),
    .core_done            (core_done),
    .s_core_tvalid        (s_core_tvalid),
    .s_core_tready        (s_core_tready),
    .s_core_tdata         (s_core_tdata),
    .s_core_tkeep         (s_core_tkeep),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tready (m_tready),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tkeep  (m_tkeep),
    .m_axis_output_tlast  (m_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Output scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    beat_t e;
    if (ap_rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_output_beat");
      end else begin
        e = exp_q.pop_front();
        check("out_beat", {m_tdata, m_tkeep, m_tlast}, e);
      end
      last_hs_cyc = cyc;
    end
    if (prev_stall && ap_rst_n)
      check("stall_hold", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {1'b1, prev_beat});
    prev_stall = ap_rst_n && m_tvalid && !m_tready;
    prev_beat  = {m_tdata, m_tkeep, m_tlast};
  end

  // Core start monitor: group index and weight address.
  always @(negedge clk) begin
    start_t s;
    if (ap_rst_n && core_start) begin
      if (start_q.size() == 0) begin
        fail_now("unexpected_core_start");
      end else begin
        s = start_q.pop_front();
        check("core_group_addr", {core_output_group, core_wt_base_addr}, s);
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    int diff;
    if (ap_rst_n && ap_done) begin
      done_cnt++;
      check("ap_ready_with_done", ap_ready, 1);
      check("beats_out_before_done", exp_q.size(), 0);
      if (chk_done_lat) begin
        diff = cyc - last_hs_cyc;
        check("done_latency_ok", (diff == 2 || diff == 3), 1);
      end
    end
  end

  // Downstream ready: steady 1 or toggling every cycle.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = toggle_mode ? !m_tready : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  function automatic beat_t mk_beat(input int tag, input int g, input int b, input int nb, input int ng);
    beat_t r;
    logic [7:0] ff = 8'hFF;
    r.d = {32'(tag), 16'(g), 16'(b)};
    r.k = ff >> (b % 8);
`ifdef SEQ_GROUP_TLAST_EN
    r.l = (b == nb - 1);
`else
    r.l = (b == nb - 1) && (g == ng - 1);
`endif
    return r;
  endfunction

  task automatic send_beat(input beat_t b, input bit with_done);
    int t = 0;
    s_core_tvalid = 1'b1;
    s_core_tdata  = b.d;
    s_core_tkeep  = b.k;
    core_done     = with_done;
    @(negedge clk);
    while (s_core_tready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("core_beat_timeout");
    @(posedge clk);
    #1;
    s_core_tvalid = 1'b0;
    core_done     = 1'b0;
  endtask

  task automatic wait_core_start();
    int t = 0;
    while (core_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("core_start_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic drive_group(input int tag, input int g, input int nb, input int ng,
                             input bit done_with_last, input bit surplus);
    bit blocked;
    wait_core_start();
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back(mk_beat(tag, g, b, nb, ng));
      send_beat(mk_beat(tag, g, b, nb, ng), done_with_last && (b == nb - 1));
    end
    if (surplus) begin
      s_core_tvalid = 1'b1;
      s_core_tdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      blocked = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (s_core_tready !== 1'b0) blocked = 1'b0;
      end
      check("surplus_backpressure", blocked, 1);
      @(posedge clk);
      #1;
      s_core_tvalid = 1'b0;
    end
    if (!done_with_last) begin
      core_done = 1'b1;
      @(posedge clk);
      #1;
      core_done = 1'b0;
    end
    if (g < ng - 1) check("next_start_latency", core_start, 1);
  endtask

  task automatic start_layer(input int ng, input logic [31:0] base, input logic [31:0] stride, input int nb);
    for (int g = 0; g < ng; g++) start_q.push_back({32'(g), base + 32'(g) * stride});
    cfg_num_groups      = 32'(ng);
    cfg_wt_base_addr    = base;
    cfg_group_wt_stride = stride;
    cfg_beats_per_group = 32'(nb);
    @(posedge clk);
    #1;
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    check("start_latency", core_start, 1);
    // Busy-time changes must not disturb the latched configuration.
    cfg_num_groups      = 32'h7;
    cfg_wt_base_addr    = 32'hDEAD_0000;
    cfg_group_wt_stride = 32'h1234;
    cfg_beats_per_group = 32'h9;
  endtask

  task automatic run_layer(input int tag, input int ng, input logic [31:0] base, input logic [31:0] stride,
                           input int nb, input bit done_with_last, input int surplus_group);
    int target = done_cnt + 1;
    int t = 0;
    chk_done_lat = 1'b1;
    start_layer(ng, base, stride, nb);
    for (int g = 0; g < ng; g++) drive_group(tag, g, nb, ng, done_with_last, g == surplus_group);
    while (done_cnt < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("layer_done_count", done_cnt, target);
    @(posedge clk);
    #1;
    check("idle_after_layer", ap_idle, 1);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    core_done = 1'b0;
    s_core_tvalid = 1'b0;
    s_core_tdata = '0;
    s_core_tkeep = '0;
    cfg_num_groups = '0;
    cfg_wt_base_addr = '0;
    cfg_group_wt_stride = '0;
    cfg_beats_per_group = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {ap_idle, ap_done, ap_ready, core_start, s_core_tready, m_tvalid, m_tlast}, 7'b1000000);
    check("reset_data", {m_tdata, m_tkeep, core_output_group, core_wt_base_addr}, 0);
    ap_rst_n = 1'b1;

    run_layer(1, 3, 32'h100, 32'h40, 4, 1'b0, -1);

    toggle_mode = 1'b1;
    run_layer(2, 3, 32'h100, 32'h40, 4, 1'b0, -1);
    toggle_mode = 1'b0;

    run_layer(3, 2, 32'h300, 32'h20, 3, 1'b1, -1);

    run_layer(4, 2, 32'h0, 32'h8, 4, 1'b0, 0);

    run_layer(5, 2, 32'hFFFF_FFF0, 32'h20, 1, 1'b0, -1);

    // Zero groups, with ignored upper bits set in the count.
    chk_done_lat = 1'b0;
    cfg_num_groups = 32'h0100_0000;
    cfg_beats_per_group = 32'd4;
    @(posedge clk);
    #1;
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    check("zero_groups_done", {ap_done, ap_ready, core_start}, 3'b110);
    @(posedge clk);
    #1;
    check("zero_groups_idle", {ap_idle, ap_done, core_start}, 3'b100);
    check("zero_groups_done_count", done_cnt, 6);

    // Reset in the middle of group 1 of 3.
    chk_done_lat = 1'b1;
    start_layer(3, 32'h200, 32'h10, 4);
    drive_group(6, 0, 4, 3, 1'b0, 1'b0);
    wait_core_start();
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back(mk_beat(6, 1, b, 4, 3));
      send_beat(mk_beat(6, 1, b, 4, 3), 1'b0);
    end
    ap_rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ctrl", {ap_idle, m_tvalid, s_core_tready, core_start, ap_done}, 5'b10000);
    check("midrst_group_addr", {core_output_group, core_wt_base_addr}, 0);
    exp_q.delete();
    start_q.delete();
    ap_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_still_idle", {ap_idle, m_tvalid}, 2'b10);

    run_layer(7, 3, 32'h100, 32'h40, 4, 1'b0, -1);

    check("final_done_count", done_cnt, 7);
    check("final_beat_queue_empty", exp_q.size(), 0);
    check("final_start_queue_empty", start_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Layer-level sequencer between the kernel's ap_ctrl_hs/AXI-Lite scalar interface and the convolution core. On one ap_start it latches the layer configuration and runs the core once per output-channel group: it issues a start pulse per group, advances the group index and weight base address, and counts output beats. It forwards the core's output stream through a 2-entry skid buffer, generates tlast, and signals ap_done after the final beat has left. This replaces one host launch per output group with one launch per layer.

## Interface
- DATA_W, 64, output stream data width (tkeep is DATA_W/8)
- CFG_W, 32, width of every configuration scalar
- CNT_W, 24, width of the group and beat counters; higher bits of cfg_num_groups and cfg_beats_per_group are ignored

- ap_clk  in  1  single clock domain
- ap_rst_n  in  1  synchronous, active-low reset
- ap_start  in  1  launch request, sampled in IDLE only
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse at layer completion
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- cfg_num_groups  in  CFG_W  output groups per layer
- cfg_wt_base_addr  in  CFG_W  weight address of group 0
- cfg_group_wt_stride  in  CFG_W  weight address increment per group
- cfg_beats_per_group  in  CFG_W  output beats expected per group
- core_start  out  1  one-cycle start pulse to the core
- core_output_group  out  CFG_W  current group index, held stable from core_start to core_done
- core_wt_base_addr  out  CFG_W  current weight base, held stable from core_start to core_done
- core_done  in  1  core completion pulse
- s_core_tvalid / s_core_tready  in / out  1  core output handshake
- s_core_tdata / s_core_tkeep  in  DATA_W / DATA_W/8  core output payload
- m_axis_output_tvalid / tready  out / in  1  kernel output handshake
- m_axis_output_tdata / tkeep / tlast  out  DATA_W / DATA_W/8 / 1  kernel output payload

## Operation
- FSM states: IDLE, LAUNCH, RUN, DRAIN, DONE.
- IDLE:
  - On ap_start, latch all four cfg_* inputs; zero the group index; set the address to the base.
  - If num_groups==0, go to DONE; otherwise go to LAUNCH.
- LAUNCH: assert core_start for 1 cycle, clear the beat counter, go to RUN.
- RUN:
  - A group is complete when core_done has been seen (sticky flag) and beat count == beats_per_group.
  - On completion with more groups left: group+1, address += stride (modulo 2^CFG_W, wrap allowed), go to LAUNCH.
  - On completion of the last group: go to DRAIN.
- DRAIN: wait until the skid buffer is empty and the last beat has been accepted downstream, then go to DONE.
- DONE: pulse ap_done and ap_ready, go to IDLE.
- s_core_tready = skid buffer not full AND state ∈ {LAUNCH, RUN} AND beat count < beats_per_group.
  - Surplus core beats are back-pressured, never dropped.
  - beats_per_group==0 completes a group on core_done alone.
- tlast is asserted on the final beat of the final group only.
- ap_start while not IDLE is ignored. cfg_* changes while busy have no effect.
- core_done arriving in the same cycle as the final beat acceptance completes the group in that cycle.

## Timing
- Reset values: ap_idle=1; ap_done, ap_ready, core_start, s_core_tready, m_axis_output_tvalid, tlast = 0; tdata, tkeep, core_output_group, core_wt_base_addr = 0.
- ap_start at cycle N (IDLE) -> core_start at N+1.
- Group completion at cycle M -> next core_start at M+1.
- A beat accepted from the core at cycle N is presented on m_axis at N+1 (registered outputs).
- The skid buffer sustains 1 beat/cycle under continuous tready. Output payload is held stable while tvalid && !tready.
- Last beat accepted downstream at cycle K -> ap_done at K+1 or K+2.
- Reset asserted mid-layer: on the next edge the block is in IDLE, the skid buffer is flushed, and all counters and flags are cleared. The core is not notified.

## Configuration
- SEQ_GROUP_TLAST_EN:
  - Defined: tlast on the last beat of every group, so the host receives one packet per group.
  - Undefined: tlast only on the final beat of the layer.
  - The macro changes no other behaviour.

## Structure
- Package conv_seq_pkg holds: the state enum type seq_state_t, and default constants for DATA_W, CFG_W and CNT_W.
- Sub-module axis_skid_buffer: 2-entry, parametrised on payload width, carrying {tdata, tkeep, tlast}. It is instantiated once.

## Test plan
- num_groups=3, base=0x100, stride=0x40, beats=4, tready=1:
  - core_output_group steps 0/1/2 with addresses 0x100/0x140/0x180.
  - 12 beats out, tlast on beat 12 only.
  - one ap_done.
- Same configuration with tready toggling 1-0 every cycle: no beat lost or duplicated; payload stable during stalls; ap_done follows the last handshake.
- num_groups=0 -> ap_done one cycle after IDLE->DONE; core_start never asserted.
- Core offers a 5th beat with beats=4 -> s_core_tready=0 for that beat until the next core_start.
- Reset asserted during group 1 of 3 -> next cycle ap_idle=1 and m_axis_output_tvalid=0; a fresh run completes normally.
- With SEQ_GROUP_TLAST_EN, 2 groups × 3 beats -> tlast on beats 3 and 6.
